// File: rtl/xpmwrap_sdpram_stream_reader_pkg.sv
// xpmwrap_pkg: shared read-latency constant and read-engine state type
package xpmwrap_pkg;
  localparam int RAM_READ_LATENCY = 2;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} rd_state_t;
endpackage

// File: rtl/xpmwrap_sdpram_stream_reader_if.sv
// xpmwrap_sdpram_stream_reader_if: valid/ready word stream; XPMWRAP_STREAM_LAST_EN adds m_last
interface xpmwrap_sdpram_stream_reader_if #(parameter int W = 32);
  logic [W-1:0] m_data;
  logic m_valid;
  logic m_ready;
`ifdef XPMWRAP_STREAM_LAST_EN
  logic m_last;
  modport master (output m_data, m_valid, m_last, input m_ready);
  modport slave (input m_data, m_valid, m_last, output m_ready);
`else
  modport master (output m_data, m_valid, input m_ready);
  modport slave (input m_data, m_valid, output m_ready);
`endif
endinterface

// File: rtl/xpmwrap_sdpram_stream_reader_fifo.sv
// xpmwrap_sync_fifo: single-clock first-word-fall-through FIFO, output read from registered storage
module xpmwrap_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic o_valid,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_cnt;
  logic w_pop;
  assign w_pop = i_pop && (r_cnt != '0);
  assign o_valid = r_cnt != '0;
  assign o_data = r_mem[r_rd];
  assign o_count = r_cnt;
  // storage is cleared so the stream data reads zero out of reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (i_push) r_mem[r_wr] <= i_data;
      r_wr <= i_push ? r_wr + AW'(1) : r_wr;
      r_rd <= w_pop ? r_rd + AW'(1) : r_rd;
      r_cnt <= r_cnt + (AW+1)'(i_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/xpmwrap_sdpram_stream_reader.sv
// xpmwrap_sdpram_stream_reader: credit-limited port-B read engine feeding a valid/ready stream
// XPMWRAP_STREAM_LAST_EN adds m_last, carried with each word through the latency pipe and FIFO
module xpmwrap_sdpram_stream_reader
  import xpmwrap_pkg::*;
#(
  parameter int ADDR_WIDTH_A = 6,
  parameter int WRITE_DATA_WIDTH_A = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clka,
  input  logic rstb,
  input  logic cmd_valid,
  output logic cmd_ready,
  input  logic [ADDR_WIDTH_A-1:0] cmd_addr,
  input  logic [ADDR_WIDTH_A:0] cmd_len,
  output logic [ADDR_WIDTH_A-1:0] ram_addrb,
  output logic ram_enb,
  output logic ram_regceb,
  output logic ram_rstb,
  input  logic [WRITE_DATA_WIDTH_A-1:0] ram_doutb,
  xpmwrap_sdpram_stream_reader_if.master m,
  output logic busy,
  output logic done
);
  localparam int CW = $clog2(FIFO_DEPTH);
  localparam int L = RAM_READ_LATENCY;
`ifdef XPMWRAP_STREAM_LAST_EN
  localparam int FW = WRITE_DATA_WIDTH_A + 1;
`else
  localparam int FW = WRITE_DATA_WIDTH_A;
`endif
  rd_state_t r_state, w_state;
  logic [ADDR_WIDTH_A-1:0] r_addr;
  logic [ADDR_WIDTH_A:0] r_rem;
  logic [L-1:0] r_pipe;
  logic [CW:0] w_cnt;
  logic [FW-1:0] w_fin, w_fout;
  logic w_accept, w_issue, w_final, w_credit, w_pop, w_fvalid;
  assign w_accept = cmd_valid && cmd_ready;
  assign w_final = r_rem == (ADDR_WIDTH_A+1)'(1);
  // reads in the latency pipe plus words already buffered must fit in the FIFO
  assign w_credit = ($countones(r_pipe) + int'(w_cnt)) < FIFO_DEPTH;
  assign w_issue = (r_state == ISSUE) && (r_rem != '0) && w_credit;
  assign w_pop = w_fvalid && m.m_ready;
  assign cmd_ready = (r_state == IDLE) && !rstb;
  assign busy = r_state != IDLE;
  assign done = r_state == DONE;
  assign ram_addrb = r_addr;
  assign ram_enb = w_issue;
  assign ram_regceb = 1'b1;
  assign ram_rstb = rstb;
  assign m.m_valid = w_fvalid;
  assign m.m_data = w_fout[WRITE_DATA_WIDTH_A-1:0];
`ifdef XPMWRAP_STREAM_LAST_EN
  logic [L-1:0] r_lpipe;
  assign w_fin = {r_lpipe[L-1], ram_doutb};
  assign m.m_last = w_fout[FW-1];
  always_ff @(posedge clka) begin
    if (rstb) r_lpipe <= '0;
    else r_lpipe <= {r_lpipe[L-2:0], w_issue && w_final};
  end
`else
  assign w_fin = ram_doutb;
`endif
  always_ff @(posedge clka) begin
    if (rstb) begin
      r_state <= IDLE;
      r_addr <= '0;
      r_rem <= '0;
      r_pipe <= '0;
    end else begin
      r_state <= w_state;
      r_pipe <= {r_pipe[L-2:0], w_issue};
      if (w_accept) begin
        r_addr <= cmd_addr;
        r_rem <= cmd_len;
      end else if (w_issue) begin
        r_addr <= r_addr + ADDR_WIDTH_A'(1);
        r_rem <= r_rem - (ADDR_WIDTH_A+1)'(1);
      end
    end
  end
  // the drain exit anticipates the pop of the last buffered word so done lands one cycle after it
  always_comb begin
    w_state = r_state;
    unique case (r_state)
      IDLE: if (w_accept) w_state = (cmd_len == '0) ? DONE : ISSUE;
      ISSUE: if (w_issue && w_final) w_state = DRAIN;
      DRAIN: if (r_pipe == '0 && (w_cnt == '0 || (w_cnt == (CW+1)'(1) && w_pop))) w_state = DONE;
      DONE: w_state = IDLE;
      default: w_state = IDLE;
    endcase
  end
  xpmwrap_sync_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clka),
    .rst(rstb),
    .i_push(r_pipe[L-1]),
    .i_data(w_fin),
    .i_pop(w_pop),
    .o_data(w_fout),
    .o_valid(w_fvalid),
    .o_count(w_cnt)
  );
endmodule

// File: doc/xpmwrap_sdpram_stream_reader.md
# xpmwrap_sdpram_stream_reader

Read-side engine for the common-clock simple dual-port RAM wrapper. It accepts a (start address, length) command and issues sequential reads on the RAM's port B, accounting for the fixed 2-cycle read latency. Returned words are delivered on a valid/ready output stream with full backpressure support. It sits between the port-B pins of the SDPRAM wrapper and any downstream consumer; the port-A writer side is untouched.

## Interface
Parameters:
- ADDR_WIDTH_A, 6, RAM address width; depth = 2**ADDR_WIDTH_A words
- WRITE_DATA_WIDTH_A, 32, RAM/stream word width
- FIFO_DEPTH, 4, output buffer depth; power of two, ≥ 4

Ports:
- clka  in  1  sole clock (RAM port B shares it, common-clock mode)
- rstb  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  engine idle, command accepted on cmd_valid&&cmd_ready
- cmd_addr  in  ADDR_WIDTH_A  first word address
- cmd_len  in  ADDR_WIDTH_A+1  word count, 0..2**ADDR_WIDTH_A
- ram_addrb  out  ADDR_WIDTH_A  to RAM addrb
- ram_enb  out  1  to RAM enb, one read per asserted cycle
- ram_regceb  out  1  to RAM regceb, constant 1
- ram_rstb  out  1  to RAM rstb, equals rstb
- ram_doutb  in  WRITE_DATA_WIDTH_A  from RAM doutb
- m_data  out  WRITE_DATA_WIDTH_A  stream data
- m_valid  out  1  stream valid
- m_ready  in  1  stream ready
- busy  out  1  command in progress
- done  out  1  one-cycle pulse, command complete

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: cmd_ready=1. On accept, latch addr and len. Go to ISSUE, or to DONE if len=0.
- ISSUE: assert ram_enb with ram_addrb=current addr only when credit allows: outstanding reads (0..2) + FIFO count < FIFO_DEPTH. After each issue, addr increments modulo 2**ADDR_WIDTH_A (wrap 63→0 at default) and remaining decrements. After the last issue, go to DRAIN.
- DRAIN: wait until outstanding = 0, FIFO empty, and the final word has handshaked. Then go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Latency tracking: a 2-bit valid shift pipe, fed by ram_enb, marks the cycle in which ram_doutb is valid. That word is pushed into the FIFO in that cycle.
- The FIFO never overflows, guaranteed by credit. The bench asserts on overflow.
- Stream handshake: m_data is held stable while m_valid && !m_ready. No drops, no duplicates, address order preserved.
- busy is 1 from the cycle after accept through the DONE cycle inclusive.
- Reset (including mid-operation): state returns to IDLE; FIFO, valid pipe, counters and credits clear; in-flight RAM data is discarded.
- Reset values: cmd_ready=0 while rstb is high, then 1; ram_enb=0, ram_addrb=0, m_valid=0, m_data=0, busy=0, done=0; ram_regceb=1.

## Timing
- Accept in cycle T. First ram_enb in T+1.
- Read issued in cycle N: ram_doutb is valid in N+2 and pushed to the FIFO; m_valid is asserted in N+3.
- With m_ready held high, throughput is 1 word/cycle.
- Len L with no backpressure: last m_valid at T+L+3, done at T+L+4, cmd_ready again at T+L+5.
- len=0: done at T+1, no ram_enb, no m_valid.
- Simultaneous FIFO push and pop with FIFO full-minus-one: both occur, count unchanged.

## Configuration
- XPMWRAP_STREAM_LAST_EN defined: adds output port m_last (1 bit).
  - m_last=1 with the final word of each command; otherwise 0; reset value 0.
  - The last marker is carried through the valid pipe and the FIFO alongside the data.
- Not defined: no m_last port and no extra storage.

## Structure
- Shared package xpmwrap_pkg holds:
  - localparam RAM_READ_LATENCY = 2;
  - enum typedef rd_state_t {IDLE, ISSUE, DRAIN, DONE}.
- Sub-module xpmwrap_sync_fifo: single-clock, first-word-fall-through with registered output, parameterised width and depth. Reusable for the write-side equivalent.

## Test plan
1. Preload mem[i]=0x100+i; cmd addr=0, len=8, m_ready=1 -> m_data 0x100..0x107 on consecutive cycles; first m_valid 3 cycles after first ram_enb; done 1 cycle after last word; with macro, m_last only on 0x107.
2. Wrap-around: addr=62, len=4 -> ram_addrb 62,63,0,1; data mem[62],mem[63],mem[0],mem[1].
3. Backpressure: len=16, m_ready high 1 cycle in 3 -> all 16 words in order, none lost or duplicated; ram_enb never asserted when outstanding+count = 4.
4. len=0 -> no ram_enb, no m_valid, done pulse in T+1, busy high exactly one cycle.
5. Reset after 3 of 10 words delivered -> next cycle m_valid=0, busy=0, ram_enb=0; a following cmd addr=5, len=2 returns exactly mem[5], mem[6] with no stale words.
6. Full memory: addr=10, len=64 -> 64 words 10..63, 0..9; done once; cmd_ready low throughout.
